ram_dma: RTL and testbench
==========================

RAM_DMA -- requirements
Module: ram_dma

Interface
REQ-001 SHALL have exactly one clock and an asynchronous, active-low reset, with ports ordered as listed below.
REQ-002 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a copy; sampled only in IDLE.
REQ-005 src_addr  input  10  first source word address.
REQ-006 dst_addr  input  10  first destination word address.
REQ-007 count  input  11  number of 16-bit words to copy.
REQ-008 busy  output  1  high while a copy is in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 mem_address  output  10  word address driven to the 1024x16 on-chip RAM.
REQ-011 mem_data_out  output  16  write data driven to the RAM data_in port.
REQ-012 mem_data_in  input  16  RAM data_out; registered, valid one cycle after an address is presented with write enable low.
REQ-013 mem_write_enable  output  1  RAM write strobe.

Function
REQ-014 SHALL latch src_addr, dst_addr and count on the rising edge where start=1 in IDLE; input changes afterwards SHALL NOT affect the copy.
REQ-015 count values above 1024 SHALL saturate to 1024.
REQ-016 SHALL implement the states IDLE, READ, HOLD, WRITE and DONE.
REQ-017 IDLE: start=1 and count>0 -> READ; start=1 and count=0 -> DONE with no memory access; otherwise stay in IDLE.
REQ-018 READ: mem_address=current source, mem_write_enable=0 -> HOLD.
REQ-019 HOLD: mem_write_enable=0; the closing edge captures mem_data_in into a 16-bit data register -> WRITE.
REQ-020 WRITE: mem_address=current destination, mem_data_out=data register, mem_write_enable=1.
REQ-021 On the closing edge of WRITE, source and destination SHALL increment modulo 1024 (1023 wraps to 0) and the remaining count SHALL decrement.
REQ-022 WRITE -> READ if the remaining count is nonzero after the decrement, else -> DONE.
REQ-023 DONE: done=1 for exactly one cycle -> IDLE.
REQ-024 Each word SHALL take exactly 3 cycles, so a copy of N>0 words keeps busy high for 3N cycles.
REQ-025 done SHALL be high in the cycle immediately after busy falls; for count=0, done SHALL be high in the cycle immediately after the start edge.
REQ-026 busy SHALL be high in the READ, HOLD and WRITE states only.
REQ-027 mem_write_enable SHALL be high only in WRITE.
REQ-028 start SHALL be ignored in READ, HOLD, WRITE and DONE, with no queuing.
REQ-029 Transfers SHALL run in ascending address order with no overlap correction.
   - When dst = src+k with 0<k<N, each source word is read after any earlier write to that address, so the first k words repeat; this is the required behaviour.
REQ-030 src equal to dst SHALL rewrite each word with its own value.
REQ-031 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-032 Asserting reset (low) SHALL immediately, without waiting for a clock edge, force:
   - state to IDLE;
   - busy=0, done=0, mem_write_enable=0;
   - mem_address=0, mem_data_out=0;
   - internal counters and the data register to 0.
REQ-033 Reset asserted during a copy SHALL abort the copy; words already written stay written, no further write occurs, and no done pulse is issued.
REQ-034 After reset is released, the block SHALL be in IDLE and SHALL accept start on the first rising edge.

Verification
REQ-035 RAM[0x010..0x012]=0x1111,0x2222,0x3333; src=0x010, dst=0x100, count=3, start pulse.
   -> busy high for 9 cycles; exactly 3 write strobes at 0x100, 0x101, 0x102 with data 0x1111, 0x2222, 0x3333; done high for 1 cycle.
REQ-036 src=0x3FF, dst=0x000, count=2 with RAM[0x3FF]=0xAAAA, RAM[0x000]=0x5555.
   -> the source wraps from 0x3FF to 0x000: first write is 0xAAAA to 0x000, second write is 0xAAAA to 0x001 (RAM[0x000] is read after it was overwritten).
REQ-037 count=0, start pulse -> busy never high; done high in the next cycle only; mem_write_enable never asserted.
REQ-038 count=2047 -> exactly 1024 writes; busy high for 3072 cycles.
REQ-039 Assert reset mid-copy in the cycle after the second WRITE of a count=5 job.
   -> all outputs are 0 before the next edge; only 2 destination words are modified; no done pulse.
REQ-040 Pulse start again while busy, with different src and dst.
   -> the pulse is ignored; the original copy completes unchanged; the cycle count matches REQ-024.

Source files
------------

// File: rtl/ram_dma.sv
`default_nettype none
// ============================================================================
// Module   : ram_dma
// Purpose  : Word-by-word copy engine for a 1024x16 on-chip RAM with a
//            registered read port. Each word costs three cycles:
//            READ (present source address), HOLD (capture read data),
//            WRITE (strobe data to destination address).
// Ports    : clk              - system clock, rising edge
//            reset            - asynchronous, active-low reset
//            start            - copy request, sampled only while idle
//            src_addr[9:0]    - first source word address
//            dst_addr[9:0]    - first destination word address
//            count[10:0]      - words to copy (values above 1024 clamp)
//            busy             - copy in progress (READ/HOLD/WRITE)
//            done             - one-cycle completion pulse
//            mem_address[9:0] - RAM word address
//            mem_data_out[15:0] - RAM write data
//            mem_data_in[15:0]  - RAM registered read data
//            mem_write_enable - RAM write strobe
// Revision : 1.0 - initial release
// ============================================================================
module ram_dma (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  src_addr,
  input  logic [9:0]  dst_addr,
  input  logic [10:0] count,
  output logic        busy,
  output logic        done,
  output logic [9:0]  mem_address,
  output logic [15:0] mem_data_out,
  input  logic [15:0] mem_data_in,
  output logic        mem_write_enable
);

  localparam logic [2:0]  c_ST_IDLE  = 3'd0;
  localparam logic [2:0]  c_ST_READ  = 3'd1;
  localparam logic [2:0]  c_ST_HOLD  = 3'd2;
  localparam logic [2:0]  c_ST_WRITE = 3'd3;
  localparam logic [2:0]  c_ST_DONE  = 3'd4;
  localparam logic [10:0] c_MAX_WORDS = 11'd1024;

  logic [2:0]  r_state;
  logic [9:0]  r_src;
  logic [9:0]  r_dst;
  logic [10:0] r_remain;
  logic [15:0] r_data;

  logic [2:0]  w_state_nxt;
  logic [9:0]  w_src_nxt;
  logic [9:0]  w_dst_nxt;
  logic [10:0] w_remain_nxt;
  logic [15:0] w_data_nxt;

  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic [9:0]  w_addr_nxt;
  logic [15:0] w_wdata_nxt;
  logic        w_we_nxt;

  // State and datapath register. Outputs are registered here too, loaded
  // from values derived from the next state so they line up with the state
  // they describe without any input-to-output combinational path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state          <= c_ST_IDLE;
      r_src            <= '0;
      r_dst            <= '0;
      r_remain         <= '0;
      r_data           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      mem_address      <= '0;
      mem_data_out     <= '0;
      mem_write_enable <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_src            <= w_src_nxt;
      r_dst            <= w_dst_nxt;
      r_remain         <= w_remain_nxt;
      r_data           <= w_data_nxt;
      busy             <= w_busy_nxt;
      done             <= w_done_nxt;
      mem_address      <= w_addr_nxt;
      mem_data_out     <= w_wdata_nxt;
      mem_write_enable <= w_we_nxt;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_src_nxt    = r_src;
    w_dst_nxt    = r_dst;
    w_remain_nxt = r_remain;
    w_data_nxt   = r_data;
    case (r_state)
      c_ST_IDLE: begin
        if (start) begin
          w_src_nxt    = src_addr;
          w_dst_nxt    = dst_addr;
          w_remain_nxt = (count > c_MAX_WORDS) ? c_MAX_WORDS : count;
          w_state_nxt  = (count == 11'd0) ? c_ST_DONE : c_ST_READ;
        end
      end
      c_ST_READ: w_state_nxt = c_ST_HOLD;
      c_ST_HOLD: begin
        // RAM output is valid now for the address presented in READ.
        w_data_nxt  = mem_data_in;
        w_state_nxt = c_ST_WRITE;
      end
      c_ST_WRITE: begin
        w_src_nxt    = r_src + 10'd1;  // natural 10-bit wrap
        w_dst_nxt    = r_dst + 10'd1;
        w_remain_nxt = r_remain - 11'd1;
        // r_remain is at least 1 here; reaching zero ends the copy.
        w_state_nxt  = (r_remain == 11'd1) ? c_ST_DONE : c_ST_READ;
      end
      c_ST_DONE: w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output values for the coming state.
  always_comb begin
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_addr_nxt  = '0;
    w_wdata_nxt = '0;
    w_we_nxt    = 1'b0;
    case (w_state_nxt)
      c_ST_READ, c_ST_HOLD: begin
        w_busy_nxt = 1'b1;
        w_addr_nxt = w_src_nxt;
      end
      c_ST_WRITE: begin
        w_busy_nxt  = 1'b1;
        w_addr_nxt  = w_dst_nxt;
        w_wdata_nxt = w_data_nxt;
        w_we_nxt    = 1'b1;
      end
      c_ST_DONE: w_done_nxt = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_dma
// Purpose  : Self-checking bench for ram_dma. Hosts a 1024x16 RAM with a
//            registered read port and compares every copy against a
//            sequential word-copy reference over a shadow memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  src_addr = '0;
  logic [9:0]  dst_addr = '0;
  logic [10:0] count = '0;
  logic        busy;
  logic        done;
  logic [9:0]  mem_address;
  logic [15:0] mem_data_out;
  logic [15:0] mem_data_in;
  logic        mem_write_enable;

  logic [15:0] ram     [0:1023];
  logic [15:0] ref_mem [0:1023];
  logic [15:0] r_rd_q = '0;
  logic        tb_we = 1'b0;
  logic [9:0]  tb_addr = '0;
  logic [15:0] tb_data = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int busy_cnt, done_cnt, done_cyc, first_busy, viol;
  logic [9:0]  obs_a [$];
  logic [15:0] obs_d [$];
  logic [9:0]  exp_a [$];
  logic [15:0] exp_d [$];

  ram_dma dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .src_addr         (src_addr),
    .dst_addr         (dst_addr),
    .count            (count),
    .busy             (busy),
    .done             (done),
    .mem_address      (mem_address),
    .mem_data_out     (mem_data_out),
    .mem_data_in      (mem_data_in),
    .mem_write_enable (mem_write_enable)
  );

  always #5 clk = ~clk;

  // RAM with registered read data; the bench port takes priority for preload.
  always @(posedge clk) begin
    if (tb_we) ram[tb_addr] <= tb_data;
    else if (mem_write_enable) ram[mem_address] <= mem_data_out;
    r_rd_q <= ram[mem_address];
  end
  assign mem_data_in = r_rd_q;

  // Output monitor, sampled 1 time unit after each rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (busy) begin
      busy_cnt++;
      if (first_busy < 0) first_busy = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (mem_write_enable) begin
      obs_a.push_back(mem_address);
      obs_d.push_back(mem_data_out);
      if (!busy) viol++;
    end
    if (busy && done) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    busy_cnt = 0; done_cnt = 0; done_cyc = -1; first_busy = -1; viol = 0;
    obs_a.delete(); obs_d.delete();
  endtask

  // Reference: copy n words in ascending order, each read seeing all earlier writes.
  task automatic model_copy(input logic [9:0] s, input logic [9:0] d, input int n);
    exp_a.delete(); exp_d.delete();
    for (int i = 0; i < n; i++) begin
      int sa, da;
      sa = (int'(s) + i) % 1024;
      da = (int'(d) + i) % 1024;
      ref_mem[da] = ref_mem[sa];
      exp_a.push_back(10'(da));
      exp_d.push_back(ref_mem[da]);
    end
  endtask

  function automatic int mem_cmp();
    int m = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) m++;
    return m;
  endfunction

  // Called at a falling edge; returns at a falling edge.
  task automatic poke(input logic [9:0] a, input logic [15:0] v);
    tb_we = 1'b1; tb_addr = a; tb_data = v; ref_mem[a] = v;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic run_job(input logic [9:0] s, input logic [9:0] d, input logic [10:0] c,
                         input bit poke_start, input string tag);
    int n, k, mm;
    n = (c > 11'd1024) ? 1024 : int'(c);
    model_copy(s, d, n);
    clear_mon();
    start = 1'b1; src_addr = s; dst_addr = d; count = c;
    k = cyc;
    @(negedge clk);
    start = 1'b0; src_addr = 10'($urandom); dst_addr = 10'($urandom); count = 11'($urandom);
    for (int i = 0; i < 3 * n + 20; i++) begin
      if (done_cnt > 0) break;
      if (poke_start && i == 3) begin
        start = 1'b1; src_addr = 10'($urandom); dst_addr = 10'($urandom); count = 11'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_busy_cycles"}, busy_cnt, 3 * n);
    chk({tag, "_done_cycle"}, done_cyc, k + 1 + 3 * n);
    if (n > 0) chk({tag, "_busy_latency"}, first_busy, k + 1);
    chk({tag, "_num_writes"}, obs_a.size(), n);
    mm = 0;
    for (int i = 0; i < n; i++)
      if (i >= obs_a.size() || obs_a[i] !== exp_a[i] || obs_d[i] !== exp_d[i]) mm++;
    chk({tag, "_write_seq_errs"}, mm, 0);
    chk({tag, "_mem_errs"}, mem_cmp(), 0);
    chk({tag, "_protocol_viol"}, viol, 0);
  endtask

  initial begin
    logic [15:0] bd [3];
    logic [9:0]  s, d;
    bd[0] = 16'h1111; bd[1] = 16'h2222; bd[2] = 16'h3333;

    // Asynchronous reset: outputs clear before any clock edge.
    #3 reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", mem_write_enable, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_data_out, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 1024; i++) begin
      tb_we = 1'b1; tb_addr = 10'(i); tb_data = 16'($urandom); ref_mem[i] = tb_data;
      @(negedge clk);
    end
    tb_we = 1'b0;

    // Basic three-word copy.
    poke(10'h010, 16'h1111); poke(10'h011, 16'h2222); poke(10'h012, 16'h3333);
    run_job(10'h010, 10'h100, 11'd3, 1'b0, "basic");
    for (int i = 0; i < 3; i++) begin
      chk("basic_addr", obs_a[i], 32'h100 + i);
      chk("basic_data", obs_d[i], bd[i]);
    end

    // Source wraps past 0x3FF into a word that was just overwritten.
    poke(10'h3FF, 16'hAAAA); poke(10'h000, 16'h5555);
    run_job(10'h3FF, 10'h000, 11'd2, 1'b0, "wrap");
    chk("wrap_a0", obs_a[0], 0);
    chk("wrap_d0", obs_d[0], 16'hAAAA);
    chk("wrap_a1", obs_a[1], 1);
    chk("wrap_d1", obs_d[1], 16'hAAAA);

    run_job(10'($urandom), 10'($urandom), 11'd0, 1'b0, "zero");

    // Random jobs, including forward overlap and src == dst.
    for (int j = 0; j < 8; j++) begin
      s = 10'($urandom);
      case (j % 3)
        0: d = 10'($urandom);
        1: d = s + 10'($urandom_range(1, 5));
        default: d = s;
      endcase
      run_job(s, d, 11'($urandom_range(1, 40)), 1'b0, "rand");
    end

    run_job(10'($urandom), 10'($urandom), 11'd2047, 1'b0, "sat");
    run_job(10'($urandom), 10'($urandom), 11'd12, 1'b1, "ignore_start");

    // Reset in the READ cycle following the second WRITE of a 5-word job.
    s = 10'($urandom); d = s + 10'd300;
    clear_mon();
    start = 1'b1; src_addr = s; dst_addr = d; count = 11'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && obs_a.size() < 2; i++) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_we", mem_write_enable, 0);
    chk("abort_addr", mem_address, 0);
    chk("abort_wdata", mem_data_out, 0);
    model_copy(s, d, 2);
    repeat (3) @(negedge clk);
    chk("abort_done_pulses", done_cnt, 0);
    chk("abort_num_writes", obs_a.size(), 2);
    chk("abort_mem_errs", mem_cmp(), 0);

    // Start presented on the very first edge after reset release.
    reset = 1'b1;
    run_job(10'($urandom), 10'($urandom), 11'd6, 1'b0, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
